// File: rtl/es24_buerste_if.sv
// Host write port and card-reader output bundle of es24_buerste.
// The reader drives timing/data into es24 and the host fills its card buffers.
interface es24_buerste_if;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [11:0] wr_data;
  logic        wr_commit;
  logic        card_ready;
  logic        run;
  logic [15:0] timing;
  logic [11:0] data;
  logic        busy;
  logic        card_done;

  modport master (
    output wr_en, wr_row, wr_data, wr_commit, run,
    input  card_ready, timing, data, busy, card_done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, wr_commit, run,
    output card_ready, timing, data, busy, card_done
  );
endinterface

// File: rtl/es24_buerste.sv
// Card-reading station: two-card ping-pong buffer played row by row (12, 11, 0..9) then a gap.
// Optional card counter (cards_read, cnt_clr) is enabled by defining ES24_BUERSTE_CARDCNT_EN.
module es24_buerste #(
  parameter int ROW_CYCLES   = 16,
  parameter int PULSE_CYCLES = 8,
  parameter int GAP_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ES24_BUERSTE_CARDCNT_EN
  input  logic        cnt_clr,
  output logic [15:0] cards_read,
`endif
  es24_buerste_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROWS, GAP} state_t;

  localparam logic [7:0] ROW_LAST   = 8'(ROW_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  logic [11:0] mem_q [2][12];
  logic [1:0]  full_q;
  logic        oldest_q;
  logic        rd_q;
  state_t      state_q;
  logic [3:0]  row_q;
  logic [7:0]  cyc_q;
  logic [15:0] timing_q;
  logic [11:0] data_q;
  logic        card_done_q;

  logic [3:0]  wr_idx_d;
  logic        wr_legal_d;
  logic        fill_d;
  logic        card_ready_d;
  logic        wr_ok_d;
  logic        commit_ok_d;
  logic [1:0]  avail_d;
  logic        sel_d;
  logic        have_d;
  logic        release_d;
  logic [3:0]  row_nxt_d;

  // Row position 0..11 carries row codes 12, 11, 0..9.
  function automatic logic [15:0] strobe(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd12;
      4'd1:    code = 4'd11;
      default: code = idx - 4'd2;
    endcase
    return 16'd1 << code;
  endfunction

  always_comb begin
    wr_idx_d   = 4'd0;
    wr_legal_d = 1'b1;
    case (bus.wr_row)
      4'd12:                      wr_idx_d   = 4'd0;
      4'd11:                      wr_idx_d   = 4'd1;
      4'd10, 4'd13, 4'd14, 4'd15: wr_legal_d = 1'b0;
      default:                    wr_idx_d   = bus.wr_row + 4'd2;
    endcase
  end

  // The buffer being read stays full until its gap ends, so the fill side never touches it.
  assign fill_d       = full_q[0];
  assign card_ready_d = ~&full_q;
  assign wr_ok_d      = bus.wr_en & wr_legal_d & card_ready_d;
  assign commit_ok_d  = bus.wr_commit & card_ready_d;
  assign avail_d      = full_q & ~((state_q != IDLE) ? (rd_q ? 2'b10 : 2'b01) : 2'b00);
  assign sel_d        = (&avail_d) ? oldest_q : avail_d[1];
  assign have_d       = |avail_d;
  assign release_d    = (state_q == GAP) && (cyc_q == GAP_LAST);
  assign row_nxt_d    = row_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 12; r++)
          mem_q[b][r] <= '0;
      full_q   <= '0;
      oldest_q <= 1'b0;
    end else begin
      if (wr_ok_d) mem_q[fill_d][wr_idx_d] <= bus.wr_data;
      if (commit_ok_d) begin
        full_q[fill_d] <= 1'b1;
        if (!full_q[~fill_d]) oldest_q <= fill_d;
      end
      if (release_d) begin
        for (int r = 0; r < 12; r++) mem_q[rd_q][r] <= '0;
        full_q[rd_q] <= 1'b0;
        oldest_q     <= ~rd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      row_q       <= '0;
      cyc_q       <= '0;
      timing_q    <= '0;
      data_q      <= '0;
      card_done_q <= 1'b0;
    end else begin
      card_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.run && have_d) begin
            state_q  <= ROWS;
            rd_q     <= sel_d;
            row_q    <= '0;
            cyc_q    <= '0;
            timing_q <= strobe(4'd0);
            data_q   <= mem_q[sel_d][0];
          end
        end
        ROWS: begin
          if (cyc_q == ROW_LAST) begin
            cyc_q <= '0;
            if (row_q == 4'd11) begin
              state_q  <= GAP;
              timing_q <= 16'h2000;
              data_q   <= '0;
            end else begin
              row_q    <= row_nxt_d;
              timing_q <= strobe(row_nxt_d);
              data_q   <= mem_q[rd_q][row_nxt_d];
            end
          end else begin
            cyc_q <= cyc_q + 8'd1;
            if (cyc_q == PULSE_LAST) begin
              timing_q <= '0;
              data_q   <= '0;
            end
          end
        end
        GAP: begin
          if (cyc_q == GAP_LAST) begin
            // Chain straight into the next card when one is already waiting.
            if (bus.run && have_d) begin
              state_q  <= ROWS;
              rd_q     <= sel_d;
              row_q    <= '0;
              cyc_q    <= '0;
              timing_q <= strobe(4'd0);
              data_q   <= mem_q[sel_d][0];
            end else begin
              state_q  <= IDLE;
              cyc_q    <= '0;
              timing_q <= '0;
              data_q   <= '0;
            end
          end else begin
            cyc_q <= cyc_q + 8'd1;
            if (cyc_q + 8'd1 == GAP_LAST) card_done_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          timing_q <= '0;
          data_q   <= '0;
        end
      endcase
    end
  end

`ifdef ES24_BUERSTE_CARDCNT_EN
  logic [15:0] cards_q;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) cards_q <= '0;
    else if (card_done_q) cards_q <= cards_q + 16'd1;
  end

  assign cards_read = cards_q;
`endif

  assign bus.card_ready = card_ready_d;
  assign bus.timing     = timing_q;
  assign bus.data       = data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.card_done  = card_done_q;
endmodule

// File: tb/tb_es24_buerste.sv
// Directed bench for es24_buerste: row-mapping vector table plus multi-card corner sequences.
`timescale 1ns/1ps
module tb_es24_buerste;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  es24_buerste_if bus();
`ifdef ES24_BUERSTE_CARDCNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] cards_read;
`endif

  es24_buerste dut (
    .clk(clk),
    .reset(reset),
`ifdef ES24_BUERSTE_CARDCNT_EN
    .cnt_clr(cnt_clr),
    .cards_read(cards_read),
`endif
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  wr_row;
    logic [11:0] wr_data;
    int          pos;
    logic [15:0] exp_timing;
  } vec_t;

  vec_t        vecs [12];
  logic [15:0] pos_timing [12];
  logic [11:0] exp_card [12];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        ready_at_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.wr_commit = 1'b0; bus.run = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_row(input logic [3:0] code, input logic [11:0] d);
    bus.wr_en = 1'b1; bus.wr_row = code; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 12; i++) exp_card[i] = '0;
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.timing[12]) found = 1'b1;
      else tick();
    end
    chk({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  // Walk one card from card cycle start_n (current sample) through the end of the gap.
  task automatic run_card(input string tag, input int start_n);
    int tmis = 0, dmis = 0, bmis = 0, done_cnt = 0, done_n = -1;
    logic [15:0] et;
    logic [11:0] ed;
    for (int n = start_n; n < 224; n++) begin
      if (n < 192) begin
        et = ((n % 16) < 8) ? pos_timing[n / 16] : 16'h0000;
        ed = ((n % 16) < 8) ? exp_card[n / 16] : 12'h000;
      end else begin
        et = 16'h2000;
        ed = 12'h000;
      end
      if (bus.timing !== et) tmis++;
      if (bus.data !== ed) dmis++;
      if (bus.busy !== 1'b1) bmis++;
      if (bus.card_done === 1'b1) begin
        done_cnt++;
        done_n = n;
        ready_at_done = bus.card_ready;
      end
      tick();
    end
    chk({tag, "_timing_errs"}, 32'(tmis), 32'd0);
    chk({tag, "_data_errs"}, 32'(dmis), 32'd0);
    chk({tag, "_busy_errs"}, 32'(bmis), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_n), 32'd223);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle_busy, stray_done, stray_busy;
    bit found;

    vecs[0]  = '{4'd3,  12'h0A5, 5,  16'h0008};
    vecs[1]  = '{4'd12, 12'h001, 0,  16'h1000};
    vecs[2]  = '{4'd9,  12'h800, 11, 16'h0200};
    vecs[3]  = '{4'd0,  12'h123, 2,  16'h0001};
    vecs[4]  = '{4'd11, 12'hFFF, 1,  16'h0800};
    vecs[5]  = '{4'd7,  12'h456, 9,  16'h0080};
    vecs[6]  = '{4'd1,  12'h789, 3,  16'h0002};
    vecs[7]  = '{4'd5,  12'hABC, 7,  16'h0020};
    vecs[8]  = '{4'd2,  12'h3C3, 4,  16'h0004};
    vecs[9]  = '{4'd8,  12'h5A5, 10, 16'h0100};
    vecs[10] = '{4'd4,  12'h00F, 6,  16'h0010};
    vecs[11] = '{4'd6,  12'hF00, 8,  16'h0040};
    for (int i = 0; i < 12; i++) pos_timing[vecs[i].pos] = vecs[i].exp_timing;

    // Reset state
    do_reset();
    chk("rst_timing", 32'(bus.timing), 32'h0);
    chk("rst_data", 32'(bus.data), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_card_done", 32'(bus.card_done), 32'h0);
    chk("rst_card_ready", 32'(bus.card_ready), 32'h1);
`ifdef ES24_BUERSTE_CARDCNT_EN
    chk("rst_cards_read", 32'(cards_read), 32'h0);
`endif

    // Test 1: sparse card, start latency
    write_row(4'd12, 12'h001);
    write_row(4'd5, 12'h800);
    commit();
    chk("t1_idle_before_run", 32'(bus.busy), 32'h0);
    bus.run = 1'b1;
    tick();
    chk("t1_first_timing", 32'(bus.timing), 32'h1000);
    chk("t1_first_data", 32'(bus.data), 32'h001);
    clear_exp();
    exp_card[0] = 12'h001;
    exp_card[7] = 12'h800;
    run_card("t1", 0);
    chk("t1_idle_after", 32'(bus.busy), 32'h0);

    // Full vector table: every row code in scrambled write order
    do_reset();
    clear_exp();
    for (int i = 0; i < 12; i++) begin
      write_row(vecs[i].wr_row, vecs[i].wr_data);
      exp_card[vecs[i].pos] = vecs[i].wr_data;
    end
    commit();
    bus.run = 1'b1;
    wait_start("vec");
    run_card("vec", 0);

    // Test 2: back-to-back cards with run held high
    do_reset();
    bus.run = 1'b1;
    write_row(4'd12, 12'h111);
    commit();
    chk("t2_not_started_yet", 32'(bus.timing), 32'h0);
    write_row(4'd12, 12'h222);
    chk("t2_a_started", 32'(bus.timing), 32'h1000);
    chk("t2_ready_before_2nd", 32'(bus.card_ready), 32'h1);
    commit();
    chk("t2_ready_fell", 32'(bus.card_ready), 32'h0);
    clear_exp();
    exp_card[0] = 12'h111;
    run_card("t2a", 1);
    chk("t2_ready_at_done", 32'(ready_at_done), 32'h0);
    chk("t2_b2b_timing", 32'(bus.timing), 32'h1000);
    chk("t2_ready_rose", 32'(bus.card_ready), 32'h1);
    exp_card[0] = 12'h222;
    run_card("t2b", 0);
    chk("t2_idle_after", 32'(bus.busy), 32'h0);

    // Test 3: illegal row codes are dropped
    do_reset();
    write_row(4'd10, 12'hFFF);
    write_row(4'd13, 12'hFFF);
    write_row(4'd15, 12'hFFF);
    commit();
    bus.run = 1'b1;
    wait_start("t3");
    clear_exp();
    run_card("t3", 0);

    // Test 4: reset during row 3
    do_reset();
    write_row(4'd12, 12'hABC);
    write_row(4'd3, 12'h5A5);
    commit();
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 82; i++) tick();
    chk("t4_in_row3_timing", 32'(bus.timing), 32'h0008);
    chk("t4_in_row3_data", 32'(bus.data), 32'h5A5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_abort_timing", 32'(bus.timing), 32'h0);
    chk("t4_abort_busy", 32'(bus.busy), 32'h0);
    chk("t4_abort_ready", 32'(bus.card_ready), 32'h1);
    stray_done = 0;
    stray_busy = 0;
    for (int i = 0; i < 260; i++) begin
      if (bus.card_done === 1'b1) stray_done++;
      if (bus.busy === 1'b1) stray_busy++;
      tick();
    end
    chk("t4_no_card_done", 32'(stray_done), 32'h0);
    chk("t4_no_busy", 32'(stray_busy), 32'h0);
    write_row(4'd12, 12'h0F0);
    commit();
    wait_start("t4");
    clear_exp();
    exp_card[0] = 12'h0F0;
    run_card("t4", 0);

    // Test 5: run dropped mid-card, second card waits; writes while not ready are ignored
    do_reset();
    write_row(4'd12, 12'h00A);
    commit();
    write_row(4'd12, 12'h00B);
    commit();
    chk("t5_ready_both_full", 32'(bus.card_ready), 32'h0);
    write_row(4'd12, 12'hFFF);
    commit();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    clear_exp();
    exp_card[0] = 12'h00A;
    run_card("t5", 0);
    idle_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy !== 1'b0) idle_busy++;
      tick();
    end
    chk("t5_stays_idle", 32'(idle_busy), 32'h0);
    chk("t5_ready_after", 32'(bus.card_ready), 32'h1);
    bus.run = 1'b1;
    tick();
    chk("t5_second_timing", 32'(bus.timing), 32'h1000);
    chk("t5_second_data", 32'(bus.data), 32'h00B);

`ifdef ES24_BUERSTE_CARDCNT_EN
    // Test 6: card counter with clear colliding with the third card_done
    do_reset();
    chk("t6_cnt_reset", 32'(cards_read), 32'h0);
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      write_row(4'd12, 12'(k + 1));
      commit();
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        if (bus.card_done === 1'b1) found = 1'b1;
        else tick();
      end
      chk("t6_done_seen", 32'(found), 32'h1);
      if (k == 2) begin
        chk("t6_cnt_before_clr", 32'(cards_read), 32'd2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t6_cnt_cleared", 32'(cards_read), 32'd0);
      end else begin
        tick();
        chk("t6_cnt_inc", 32'(cards_read), 32'(k + 1));
      end
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/es24_buerste.md
Name: es24_buerste

Overview:
- Card-reading station model directly upstream of the es24 counter bank.
- Holds up to two punched-card images in a ping-pong buffer, filled by a host-side write port.
- Plays each card row by row, in Dehomag row order 12, 11, 0, 1 … 9, on timing[15:0] and data[12:1], which wire straight into es24.
- Then emits an inter-card gap, during which es24 settles its carries.

Parameters:
- ROW_CYCLES, 16: clocks per row position. Legal range PULSE_CYCLES+4 … 255.
- PULSE_CYCLES, 8: clocks per row during which timing and data are high. Legal range 4 … ROW_CYCLES-4.
- GAP_CYCLES, 32: clocks of the inter-card gap after row 9. Minimum 8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one row into the fill buffer
- wr_row  in  4  row code: 0–9, 11 or 12; codes 10, 13, 14, 15 are illegal
- wr_data  in  12  row punches, bit0 = column 1
- wr_commit  in  1  mark the fill buffer as a complete card
- card_ready  out  1  a fill buffer is free
- run  in  1  level; card feed enabled
- timing  out  16  one-hot row strobe. Bits 0–9, 11 and 12 are rows; bit 13 is the gap; bits 10, 14 and 15 are always 0.
- data  out  12  punches of the current row; bit 11 = column 12
- busy  out  1  a card is being read (rows or gap)
- card_done  out  1  one-cycle pulse at the end of the gap

Behaviour:
- Reset:
  - both buffers are cleared to all-zero and marked empty; state is IDLE.
  - timing = 0, data = 0, busy = 0, card_done = 0, card_ready = 1.
  - Reset mid-card aborts the card immediately, with no card_done.
- Buffers: two entries, each 12 rows × 12 bits plus a full flag.
  - The fill pointer selects the lowest-index empty buffer that is not being read.
  - wr_en writes wr_data into the selected row of the fill buffer.
  - wr_en with an illegal row code is ignored.
  - wr_en or wr_commit while card_ready = 0 is ignored.
  - Rows that are never written read as 0.
  - wr_en and wr_commit in the same cycle: the write lands first, then the commit.
  - card_ready = 0 exactly when both buffers are full, or one is full and the other is being read.
- States: IDLE, ROWS, GAP.
  - IDLE → ROWS on the edge where run = 1 and a full buffer exists. With two full buffers, the older commit is taken first.
  - ROWS: row index r = 0 … 11 maps to row codes 12, 11, 0, 1 … 9. Each row position lasts ROW_CYCLES clocks.
  - For the first PULSE_CYCLES clocks of each position, timing[code] = 1 and data = buffer row. For the rest of the position, timing = 0 and data = 0.
  - Outputs are registered: timing[12] is high in the cycle after the IDLE → ROWS edge.
  - After position r = 11 completes → GAP. timing[13] = 1 for all GAP_CYCLES clocks; data = 0.
  - On the last GAP cycle: card_done = 1. On the same edge the buffer is cleared and marked empty, making it available for filling from the next cycle.
  - From the end of GAP, go directly to ROWS if run = 1 and another buffer is full; otherwise go to IDLE.
- busy = 1 in ROWS and GAP.
- run falling mid-card does not stop the card; it is finished, and the block then idles.
- Commit arriving while IDLE with run = 1: the card starts on the following edge.
- A card is never shorter than 12 × ROW_CYCLES + GAP_CYCLES clocks; total per card is 224 clocks at the defaults.
- Row and gap counters are 8-bit; no wrap occurs within legal parameter ranges.

Optional Feature:
- Macro: ES24_BUERSTE_CARDCNT_EN.
- When defined:
  - adds output port cards_read [15:0], reset to 0;
  - it increments on each card_done and wraps from 16'hFFFF to 0;
  - adds input cnt_clr, which zeroes the counter synchronously and wins over a simultaneous increment.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
1. Reset, then write row 12 = 12'h001 and row 5 = 12'h800, commit, run = 1. Required response:
   - timing[12] is high for 8 clocks with data = 12'h001;
   - the row-5 position (8th) shows data = 12'h800;
   - timing[13] is high for 32 clocks;
   - card_done pulses once, 224 clocks after start.
2. Commit two cards back-to-back, run held at 1. Required response:
   - card_ready falls after the second commit;
   - the second card's timing[12] follows card_done by exactly one clock;
   - card_ready rises on the cycle after the first card_done.
3. Write row code 10 with data 12'hFFF, then commit. Required response: every data output is 0 for the whole card.
4. Assert reset during row 3 of a card. Required response:
   - the next cycle shows timing = 0, busy = 0, card_ready = 1;
   - no card_done is generated;
   - a fresh commit restarts from row 12.
5. Drop run during row 0. Required response: the card completes with card_done, then the block stays IDLE although a second full buffer is waiting.
6. With ES24_BUERSTE_CARDCNT_EN defined, read 3 cards and pulse cnt_clr on the same cycle as the 3rd card_done. Required response: cards_read reads 2, then 0.
